uart_hex_fmt: RTL and testbench

UART_HEX_FMT -- requirements
Module: uart_hex_fmt

---
 rtl/uart_hex_fmt.sv | 127 ++++++++++++
 tb/tb_uart_hex_fmt.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_hex_fmt
//  Description : Formats a NIBBLES-digit word as uppercase ASCII hex, most
//                significant digit first, optionally followed by CR LF, and
//                streams the bytes to a UART transmitter over a valid/ready
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_hex_fmt #(
    parameter int NIBBLES = 4,
    parameter int EOL     = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [4*NIBBLES-1:0]   i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [7:0]             o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_busy
);

    localparam int         c_W          = 4 * NIBBLES;
    localparam logic [3:0] c_LAST       = 4'(NIBBLES - 1);
    localparam logic [7:0] c_ASCII_CR   = 8'h0D;
    localparam logic [7:0] c_ASCII_LF   = 8'h0A;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HEX  = 2'd1;
    localparam logic [1:0] c_CR   = 2'd2;
    localparam logic [1:0] c_LF   = 2'd3;

    logic [1:0]     r_state;
    logic [c_W-1:0] r_word;      // digit being shown sits in the top nibble
    logic [3:0]     r_cnt;       // index of the digit currently on o_data
    logic [c_W-1:0] w_word_shl;
    logic           w_in_hs;
    logic           w_out_hs;
    logic           w_last_digit;
    logic [7:0]     w_first_char;
    logic [7:0]     w_next_char;

    // Uppercase hex digit to ASCII: 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign w_in_hs      = i_valid & o_ready;
    assign w_out_hs     = o_valid & i_ready;
    assign w_last_digit = (r_cnt == c_LAST);
    // For NIBBLES=1 this is all zero, but it is never used on the last digit
    assign w_word_shl   = r_word << 4;
    assign w_first_char = hex_ascii(i_data[c_W-1 -: 4]);
    assign w_next_char  = hex_ascii(w_word_shl[c_W-1 -: 4]);

    // Formatter FSM; every output is registered so o_valid/o_data only
    // change on the cycle after a handshake and never retract.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
            r_word  <= '0;
            r_cnt   <= '0;
            o_data  <= 8'h00;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_in_hs) begin
                        r_word  <= i_data;
                        r_cnt   <= '0;
                        o_data  <= w_first_char;
                        o_valid <= 1'b1;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        r_state <= c_HEX;
                    end
                end
                c_HEX: begin
                    if (w_out_hs) begin
                        if (w_last_digit) begin
                            r_cnt <= '0;
                            if (EOL != 0) begin
                                o_data  <= c_ASCII_CR;
                                r_state <= c_CR;
                            end else begin
                                o_valid <= 1'b0;
                                o_ready <= 1'b1;
                                o_busy  <= 1'b0;
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_cnt  <= r_cnt + 4'd1;
                            r_word <= w_word_shl;
                            o_data <= w_next_char;
                        end
                    end
                end
                c_CR: begin
                    if (w_out_hs) begin
                        o_data  <= c_ASCII_LF;
                        r_state <= c_LF;
                    end
                end
                c_LF: begin
                    if (w_out_hs) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_hex_fmt
//  Description : Directed self-checking bench for uart_hex_fmt. Instance A
//                uses the defaults (4 digits + CR LF), instance B uses
//                NIBBLES=2, EOL=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_hex_fmt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] a_data;
    logic        a_valid, a_ready;
    logic [7:0]  a_odata;
    logic        a_ovalid, a_oready, a_busy;
    logic [7:0]  b_data;
    logic        b_valid, b_ready;
    logic [7:0]  b_odata;
    logic        b_ovalid, b_oready, b_busy;

    int n_errors = 0;
    int n_checks = 0;
    int cyc      = 0;

    logic [7:0] rx_a[$];
    int         rx_a_t[$];
    logic [7:0] rx_b[$];

    uart_hex_fmt u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (a_data),
        .i_valid (a_valid),
        .o_ready (a_oready),
        .o_data  (a_odata),
        .o_valid (a_ovalid),
        .i_ready (a_ready),
        .o_busy  (a_busy)
    );

    uart_hex_fmt #(.NIBBLES(2), .EOL(0)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (b_data),
        .i_valid (b_valid),
        .o_ready (b_oready),
        .o_data  (b_odata),
        .o_valid (b_ovalid),
        .i_ready (b_ready),
        .o_busy  (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte collectors on the falling edge: record each handshake and
    // confirm a stalled byte is held unchanged until it is taken.
    logic       a_stall = 1'b0;
    logic [7:0] a_stall_data = 8'h00;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            a_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check("hold_valid", {31'd0, a_ovalid}, 32'd1);
                check("hold_data", {24'd0, a_odata}, {24'd0, a_stall_data});
            end
            if (a_ovalid && a_ready) begin
                rx_a.push_back(a_odata);
                rx_a_t.push_back(cyc);
            end
            a_stall      = a_ovalid && !a_ready;
            a_stall_data = a_odata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_ovalid && b_ready)
            rx_b.push_back(b_odata);
    end

    task automatic check_rx_a(input string tag, input int n, input logic [95:0] exp);
        logic [7:0]  e;
        logic [31:0] g;
        check({tag, "_count"}, rx_a.size(), n);
        for (int i = 0; i < n; i++) begin
            e = exp[8*(n-1-i) +: 8];
            g = (i < rx_a.size()) ? {24'd0, rx_a[i]} : 32'hFFFF_FFFF;
            check($sformatf("%s[%0d]", tag, i), g, {24'd0, e});
        end
    endtask

    task automatic send_a(input logic [15:0] d);
        for (int k = 0; k < 50 && !a_oready; k++) step();
        check("ready_wait", {31'd0, a_oready}, 32'd1);
        a_data  = d;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int limit);
        for (int k = 0; k < limit && a_busy; k++) step();
        check("idle_wait", {31'd0, a_busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        logic [47:0] e34;
        rst_n   = 1'b0;
        a_data  = '0; a_valid = 1'b0; a_ready = 1'b0;
        b_data  = '0; b_valid = 1'b0; b_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_a_ready", {31'd0, a_oready}, 32'd1);
        check("rst_a_valid", {31'd0, a_ovalid}, 32'd0);
        check("rst_a_data",  {24'd0, a_odata}, 32'd0);
        check("rst_a_busy",  {31'd0, a_busy}, 32'd0);
        check("rst_b_ready", {31'd0, b_oready}, 32'd1);
        check("rst_b_valid", {31'd0, b_ovalid}, 32'd0);

        // 0x1A2F accepted on the first edge after reset release, one byte per cycle
        rst_n   = 1'b1;
        a_data  = 16'h1A2F;
        a_valid = 1'b1;
        a_ready = 1'b1;
        step();
        a_valid = 1'b0;
        e34 = 48'h3141_3246_0D0A;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("seq_valid[%0d]", k), {31'd0, a_ovalid}, 32'd1);
            check($sformatf("seq_data[%0d]", k), {24'd0, a_odata}, {24'd0, e34[8*(5-k) +: 8]});
            check($sformatf("seq_ready[%0d]", k), {31'd0, a_oready}, 32'd0);
            check($sformatf("seq_busy[%0d]", k), {31'd0, a_busy}, 32'd1);
            step();
        end
        check("seq_end_valid", {31'd0, a_ovalid}, 32'd0);
        check("seq_end_ready", {31'd0, a_oready}, 32'd1);
        check("seq_end_busy",  {31'd0, a_busy}, 32'd0);
        check_rx_a("seq_rx", 6, 96'h3141_3246_0D0A);

        // 0xBEEF with a randomly stalling transmitter
        rx_a.delete(); rx_a_t.delete();
        a_ready = 1'b0;
        send_a(16'hBEEF);
        for (int k = 0; k < 300 && a_busy; k++) begin
            a_ready = 1'($urandom_range(0, 1));
            step();
        end
        check("beef_done", {31'd0, a_busy}, 32'd0);
        a_ready = 1'b1;
        check_rx_a("beef_rx", 6, 96'h4245_4546_0D0A);

        // 0x0000 then 0xFFFF with i_valid held high
        rx_a.delete(); rx_a_t.delete();
        step();
        a_data  = 16'h0000;
        a_valid = 1'b1;
        step();
        a_data = 16'hFFFF;
        repeat (6) step();
        check("b2b_gap_valid", {31'd0, a_ovalid}, 32'd0);
        check("b2b_gap_ready", {31'd0, a_oready}, 32'd1);
        step();
        a_valid = 1'b0;
        check("b2b_second_valid", {31'd0, a_ovalid}, 32'd1);
        check("b2b_second_data", {24'd0, a_odata}, 32'h46);
        wait_idle_a(40);
        check_rx_a("b2b_rx", 12, 96'h3030_3030_0D0A_4646_4646_0D0A);
        if (rx_a_t.size() >= 12) begin
            check("b2b_first_span", rx_a_t[5] - rx_a_t[0], 5);
            check("b2b_gap", rx_a_t[6] - rx_a_t[5], 2);
            check("b2b_second_span", rx_a_t[11] - rx_a_t[6], 5);
        end

        // NIBBLES=2, EOL=0: 0x9A -> "9A" only
        b_ready = 1'b1;
        b_data  = 8'h9A;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("b_d0_valid", {31'd0, b_ovalid}, 32'd1);
        check("b_d0_data", {24'd0, b_odata}, 32'h39);
        step();
        check("b_d1_data", {24'd0, b_odata}, 32'h41);
        check("b_d1_busy", {31'd0, b_busy}, 32'd1);
        step();
        check("b_end_valid", {31'd0, b_ovalid}, 32'd0);
        check("b_end_ready", {31'd0, b_oready}, 32'd1);
        check("b_end_busy", {31'd0, b_busy}, 32'd0);
        step();
        check("b_rx_count", rx_b.size(), 2);
        if (rx_b.size() == 2) begin
            check("b_rx0", {24'd0, rx_b[0]}, 32'h39);
            check("b_rx1", {24'd0, rx_b[1]}, 32'h41);
        end

        // Pulse of 0x1234 while 0x5678 is in flight is ignored
        rx_a.delete(); rx_a_t.delete();
        send_a(16'h5678);
        a_data  = 16'h1234;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        a_data  = 16'h0000;
        wait_idle_a(40);
        repeat (3) step();
        check_rx_a("ignore_rx", 6, 96'h3536_3738_0D0A);

        // Reset after the second byte of 0x1A2F abandons the word
        rx_a.delete(); rx_a_t.delete();
        send_a(16'h1A2F);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, a_ovalid}, 32'd0);
        check("midrst_ready", {31'd0, a_oready}, 32'd1);
        check("midrst_busy",  {31'd0, a_busy}, 32'd0);
        check("midrst_data",  {24'd0, a_odata}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check_rx_a("midrst_rx", 2, 96'h3141);
        check("midrst_idle_valid", {31'd0, a_ovalid}, 32'd0);
        rx_a.delete(); rx_a_t.delete();
        send_a(16'h0007);
        wait_idle_a(40);
        check_rx_a("after_rst_rx", 6, 96'h3030_3037_0D0A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
